l1_bus_arbiter: RTL and testbench
=================================

# l1_bus_arbiter

Shares the single cache-to-bus port between the L1I refill path (read bursts only) and the L1D path (read refills and write-backs). A whole 4-beat, 16-byte-aligned burst is granted to one requester at a time. The block sequences the beat addresses, counts issued and returned beats, and routes returned data to the owner. It sits between the two L1 transform blocks and the bus handshake logic.

## Interface
- BURST_BEATS, 4: beats per burst, 32-bit each; fixed by line size.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_req  in  1  L1I burst-read request; held until i_done
- i_addr  in  32  L1I miss address; bits [3:0] ignored
- i_gnt  out  1  L1I owns the bus
- i_rvalid  out  1  read beat valid for L1I
- i_rdata  out  32  read beat data
- i_done  out  1  one-cycle pulse: L1I burst complete
- d_req  in  1  L1D burst request; held until d_done
- d_we  in  1  1 = write-back, 0 = refill read; sampled at grant
- d_addr  in  32  L1D line address; bits [3:0] ignored
- d_wdata  in  32  current write beat, lowest word first
- d_wready  out  1  write beat accepted; L1D advances to next word
- d_gnt, d_rvalid, d_rdata, d_done  out  1/1/32/1  same meaning as the i_ signals
- bus_valid  out  1  beat request valid
- bus_rw  out  1  1 = read, 0 = write
- bus_addr  out  32  beat address
- bus_wdata  out  32  write beat data; 0 when not writing
- bus_ready  in  1  beat accepted by bus this cycle
- bus_rvalid  in  1  read data beat valid
- bus_rdata  in  32  read data

## Operation
- States: IDLE, BURST, DONE.
- IDLE: if any request is present, latch the owner, {addr[31:4],4'b0} and rw (I is always a read), clear both counters, and go to BURST.
- Arbitration when both requests are present: round-robin on the last owner. The reset value of last owner is D, so I wins the first tie. A lone request always wins.
- BURST:
  - bus_valid is high while issued < 4.
  - bus_addr = {base[31:4], issued[1:0], 2'b00}.
  - Each cycle with bus_valid && bus_ready increments issued.
  - For writes, d_wready pulses on each such cycle and bus_wdata = d_wdata.
- Read return:
  - Each bus_rvalid in BURST with an owner reading increments returned and drives the owner's rvalid/rdata, which are combinational pass-through.
  - bus_rvalid in any other state, or beyond 4 beats, is dropped.
- BURST exits to DONE when issued == 4 and (write, or returned == 4).
- DONE: the owner's done pulses for one cycle, gnt drops, last owner is updated, and the state goes to IDLE.
- Deasserting req mid-burst does not abort; the burst completes and done still pulses.
- Counters are 3 bits and saturate at 4, with no wrap.
- Reset mid-burst: return to IDLE immediately and clear counters; no done pulse.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0; last owner D.
- Request seen at edge N in IDLE: gnt and bus_valid are high from cycle N+1.
- With bus_ready held high, beats issue in cycles N+1..N+4.
- Read with rvalid one cycle after each accept: returns in N+2..N+5, done in N+6, IDLE in N+7. The earliest next grant is N+8.
- Write with ready held high: done in N+5.
- gnt is high from N+1 through the DONE cycle inclusive.
- bus_ready low stalls: bus_addr and bus_wdata hold and issued holds.

## Configuration
- L1_ARB_ROUND_ROBIN_EN defined: round-robin tie-break as above.
- Not defined: fixed priority, D over I; the last-owner register is removed.

## Structure
- The shared define header (src/common/Define.v) holds:
  - state encodings IDLE=2'b00, BURST=2'b01, DONE=2'b10
  - owner codes OWN_I=1'b0, OWN_D=1'b1
  - BURST_BEATS
  - the bus_rw encoding
- One sub-module, l1_arb_beat_cnt: a saturating 3-bit counter with clear, increment and full. It is instantiated twice, for issued and returned.

## Test plan
- Lone I request at 0x8000_1234, ready=1, rvalid delayed 1: bus_addr is 0x8000_1230/34/38/3C, i_rvalid ×4, i_done in N+6, d_rvalid stays 0.
- D write-back to 0x0000_0040, wdata 0xA0..0xA3, ready toggling 1,0,1,1,0,1: exactly 4 d_wready pulses, with bus_wdata stable while stalled, then d_done.
- Simultaneous I and D requests right after reset, both held (RR build): I is granted first, D on the next arbitration; in the non-RR build, D is first.
- Stray bus_rvalid in IDLE and a 5th rvalid within a burst: no i_rvalid/d_rvalid for either, counts unaffected.
- rst_n low after beat 2 of an I read: all outputs 0 and no i_done. After release, a fresh burst restarts at offset 0x0.

Source files
------------

// File: rtl/l1_bus_arbiter_pkg.sv
// Shared types and constants for the L1 bus arbiter.
// State, owner and bus direction encodings plus burst length.
package l1_bus_arbiter_pkg;

  localparam int BURST_BEATS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BURST = 2'b01,
    DONE  = 2'b10
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic BUS_RD = 1'b1;
  localparam logic BUS_WR = 1'b0;

endpackage

// File: rtl/l1_bus_arbiter_beat_cnt.sv
// Saturating 3-bit beat counter with clear, increment and full flag.
// Holds at BURST_BEATS; never wraps.
module l1_arb_beat_cnt
  import l1_bus_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [2:0] cnt,
  output logic       full
);

  assign full = (cnt == 3'(BURST_BEATS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !full) begin
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/l1_bus_arbiter.sv
// L1I/L1D burst arbiter for the shared cache-to-bus port.
// L1_ARB_ROUND_ROBIN_EN selects round-robin ties; else D beats I.
module l1_bus_arbiter
  import l1_bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_wready,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        bus_valid,
  output logic        bus_rw,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  state_t      state, state_nx;
  owner_t      owner, pick;
  logic        rd;
  logic [27:0] base;

  logic [2:0]  iss, ret;
  logic        iss_full, ret_full;
  logic        cnt_clr, inc_iss, inc_ret;
  logic        iss_end, ret_end;
  logic        in_burst, wr_act;
  logic        unused_lo;

  assign unused_lo = ^{i_addr[3:0], d_addr[3:0]};

`ifdef L1_ARB_ROUND_ROBIN_EN
  owner_t last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= OWN_D;
    end else if (state == DONE) begin
      last <= owner;
    end
  end

  always_comb begin
    pick = OWN_I;
    if (i_req && d_req) begin
      pick = (last == OWN_D) ? OWN_I : OWN_D;
    end else if (d_req) begin
      pick = OWN_D;
    end
  end
`else
  always_comb begin
    pick = OWN_I;
    if (d_req) begin
      pick = OWN_D;
    end
  end
`endif

  l1_arb_beat_cnt u_iss (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (inc_iss),
    .cnt   (iss),
    .full  (iss_full)
  );

  l1_arb_beat_cnt u_ret (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (inc_ret),
    .cnt   (ret),
    .full  (ret_full)
  );

  assign in_burst = (state == BURST);
  assign cnt_clr  = (state == IDLE);
  assign bus_valid = in_burst && !iss_full;
  assign inc_iss  = bus_valid && bus_ready;
  assign inc_ret  = in_burst && rd && bus_rvalid && !ret_full;
  assign wr_act   = bus_valid && !rd;

  // Count the beat landing this cycle so DONE follows the last beat directly
  assign iss_end = iss_full ||
                   (iss == 3'(BURST_BEATS - 1) && inc_iss);
  assign ret_end = ret_full ||
                   (ret == 3'(BURST_BEATS - 1) && inc_ret);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_req || d_req) state_nx = BURST;
      end
      BURST: begin
        if (iss_end && (!rd || ret_end)) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= OWN_I;
      rd    <= 1'b0;
      base  <= '0;
    end else if (state == IDLE && (i_req || d_req)) begin
      owner <= pick;
      rd    <= (pick == OWN_I) ? 1'b1 : !d_we;
      base  <= (pick == OWN_I) ? i_addr[31:4] : d_addr[31:4];
    end
  end

  assign bus_rw    = in_burst ? (rd ? BUS_RD : BUS_WR) : 1'b0;
  assign bus_addr  = in_burst ? {base, iss[1:0], 2'b00} : '0;
  assign bus_wdata = wr_act ? d_wdata : '0;
  assign d_wready  = wr_act && bus_ready;

  assign i_gnt    = (state != IDLE) && (owner == OWN_I);
  assign d_gnt    = (state != IDLE) && (owner == OWN_D);
  assign i_done   = (state == DONE) && (owner == OWN_I);
  assign d_done   = (state == DONE) && (owner == OWN_D);
  assign i_rvalid = inc_ret && (owner == OWN_I);
  assign d_rvalid = inc_ret && (owner == OWN_D);
  assign i_rdata  = i_rvalid ? bus_rdata : '0;
  assign d_rdata  = d_rvalid ? bus_rdata : '0;

endmodule

// File: tb/tb_l1_bus_arbiter.sv
// Directed bench for l1_bus_arbiter.
// Tie-break expectations follow L1_ARB_ROUND_ROBIN_EN.
module tb_l1_bus_arbiter;

`ifdef L1_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid, i_done;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_wready, d_gnt, d_rvalid, d_done;
  logic [31:0] d_rdata;
  logic        bus_valid, bus_rw;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ready, bus_rvalid;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  int pulses;
  int w;
  bit rdy [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  l1_bus_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .i_done     (i_done),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_wready   (d_wready),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_done     (d_done),
    .bus_valid  (bus_valid),
    .bus_rw     (bus_rw),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input logic exp_d, input string tag);
    int n;
    n = 0;
    #1;
    while (!(i_done || d_done) && n < 16) begin
      cyc();
      #1;
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 16), 32'd1);
    chk({tag, "_d_done"}, 32'(d_done), 32'(exp_d));
    chk({tag, "_i_done"}, 32'(i_done), 32'(!exp_d));
  endtask

  initial begin
    rst_n = 1'b0;
    i_req = 1'b0;
    i_addr = '0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    bus_ready = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata = '0;
    cyc();
    cyc();
    chk("rst_ctl",
        32'({i_gnt, i_rvalid, i_done, d_gnt, d_rvalid,
             d_done, d_wready, bus_valid, bus_rw}), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Lone I read, rvalid one cycle behind each accept
    i_req = 1'b1;
    i_addr = 32'h8000_1234;
    bus_ready = 1'b1;
    cyc();
    #1;
    chk("t1_gnt", 32'(i_gnt), 32'd1);
    chk("t1_valid", 32'(bus_valid), 32'd1);
    chk("t1_rw", 32'(bus_rw), 32'd1);
    chk("t1_addr0", bus_addr, 32'h8000_1230);
    chk("t1_norv", 32'(i_rvalid), 32'd0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      bus_rvalid = 1'b1;
      bus_rdata = 32'h1111_0000 + 32'(k);
      #1;
      chk($sformatf("t1_rv%0d", k), 32'(i_rvalid), 32'd1);
      chk($sformatf("t1_rd%0d", k), i_rdata, 32'h1111_0000 + 32'(k));
      chk($sformatf("t1_drv%0d", k), 32'(d_rvalid), 32'd0);
      chk($sformatf("t1_done%0d", k), 32'(i_done), 32'd0);
      if (k < 3) begin
        chk($sformatf("t1_addr%0d", k + 1), bus_addr,
            32'h8000_1230 + 32'(4 * (k + 1)));
      end else begin
        chk("t1_valid_off", 32'(bus_valid), 32'd0);
      end
      cyc();
    end
    bus_rvalid = 1'b0;
    #1;
    chk("t1_done", 32'(i_done), 32'd1);
    chk("t1_gnt_done", 32'(i_gnt), 32'd1);
    i_req = 1'b0;
    cyc();
    #1;
    chk("t1_done_off", 32'(i_done), 32'd0);
    chk("t1_gnt_off", 32'(i_gnt), 32'd0);

    // D write-back with stalls
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h0000_0040;
    d_wdata = 32'hA0;
    cyc();
    w = 0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      bus_ready = rdy[k];
      d_wdata = 32'hA0 + 32'(w);
      #1;
      chk($sformatf("t2_wrdy%0d", k), 32'(d_wready), 32'(rdy[k]));
      chk($sformatf("t2_wdata%0d", k), bus_wdata, 32'hA0 + 32'(w));
      chk($sformatf("t2_addr%0d", k), bus_addr, 32'h40 + 32'(4 * w));
      chk($sformatf("t2_rw%0d", k), 32'(bus_rw), 32'd0);
      if (d_wready) pulses++;
      if (rdy[k]) w++;
      cyc();
    end
    #1;
    chk("t2_pulses", 32'(pulses), 32'd4);
    chk("t2_done", 32'(d_done), 32'd1);
    chk("t2_wrdy_off", 32'(d_wready), 32'd0);
    chk("t2_wdata_off", bus_wdata, 32'd0);
    d_req = 1'b0;
    cyc();
    #1;
    chk("t2_done_off", 32'(d_done), 32'd0);
    chk("t2_gnt_off", 32'(d_gnt), 32'd0);

    // Simultaneous requests straight after reset
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    i_req = 1'b1;
    d_req = 1'b1;
    d_we = 1'b0;
    i_addr = 32'h0000_0100;
    d_addr = 32'h0000_0208;
    bus_ready = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata = 32'h55;
    cyc();
    #1;
    chk("t3_first_i", 32'(i_gnt), 32'(RR));
    chk("t3_first_d", 32'(d_gnt), 32'(!RR));
    chk("t3_first_addr", bus_addr, RR ? 32'h100 : 32'h200);
    wait_done(!RR, "t3_first");
    if (!RR) d_req = 1'b0;
    cyc();
    cyc();
    #1;
    chk("t3_second_i", 32'(i_gnt), 32'(!RR));
    chk("t3_second_d", 32'(d_gnt), 32'(RR));
    chk("t3_second_addr", bus_addr, RR ? 32'h200 : 32'h100);
    wait_done(RR, "t3_second");
    i_req = 1'b0;
    d_req = 1'b0;
    bus_rvalid = 1'b0;
    cyc();
    cyc();

    // Stray rvalid in IDLE and a fifth rvalid inside a burst
    bus_rvalid = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t4_idle_irv", 32'(i_rvalid), 32'd0);
    chk("t4_idle_drv", 32'(d_rvalid), 32'd0);
    chk("t4_idle_rdata", i_rdata | d_rdata, 32'd0);
    cyc();
    i_req = 1'b1;
    i_addr = 32'h0000_0300;
    bus_ready = 1'b0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t4_irv%0d", k), 32'(i_rvalid), 32'(k < 4));
      chk($sformatf("t4_drv%0d", k), 32'(d_rvalid), 32'd0);
      chk($sformatf("t4_hold%0d", k), bus_addr, 32'h300);
      cyc();
    end
    bus_rvalid = 1'b0;
    bus_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t4_addr%0d", k), bus_addr, 32'h300 + 32'(4 * k));
      chk($sformatf("t4_nodone%0d", k), 32'(i_done), 32'd0);
      cyc();
    end
    #1;
    chk("t4_done", 32'(i_done), 32'd1);
    i_req = 1'b0;
    cyc();
    cyc();

    // Reset in the middle of an I read
    i_req = 1'b1;
    i_addr = 32'h8000_1234;
    bus_ready = 1'b1;
    cyc();
    cyc();
    bus_rvalid = 1'b1;
    bus_rdata = 32'h77;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ctl",
        32'({i_gnt, i_rvalid, i_done, d_gnt, d_rvalid,
             d_done, d_wready, bus_valid, bus_rw}), 32'd0);
    chk("t5_rst_addr", bus_addr, 32'd0);
    chk("t5_rst_rdata", i_rdata, 32'd0);
    cyc();
    #1;
    chk("t5_no_done", 32'(i_done), 32'd0);
    rst_n = 1'b1;
    bus_rvalid = 1'b0;
    cyc();
    #1;
    chk("t5_regnt", 32'(i_gnt), 32'd1);
    chk("t5_restart", bus_addr, 32'h8000_1230);
    i_req = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
